// File: rtl/video_timing.sv
// video_timing: free-running 800x600@60 raster timing generator (40 MHz pixel clock).
// Keeps the horizontal/vertical position counters and decodes sync, active video,
// the next-line look-ahead used by the line fetcher, and frame strobes/count.
//
// Ports:
//   clk40           in   pixel clock
//   rst_n           in   asynchronous active-low reset
//   hPos            out  current horizontal position, 0..H_TOTAL-1
//   vPos            out  current vertical position, 0..V_TOTAL-1
//   videoActive     out  current pixel is visible
//   hsync, vsync    out  sync pulses at the SYNC_POL level
//   nextVPos        out  line displayed after the current one
//   nextFrameActive out  nextVPos is a visible line
//   lineStarting    out  1-cycle pulse LEAD cycles before a visible line begins
//   lineEnding      out  1-cycle pulse on the last visible pixel of a line
//   frameStart      out  1-cycle pulse at position (0,0)
//   frameCount      out  frame counter, wraps modulo 256
module video_timing #(
    parameter int unsigned H_VISIBLE = 800,
    parameter int unsigned H_FP      = 40,
    parameter int unsigned H_SYNC    = 128,
    parameter int unsigned H_BP      = 88,
    parameter int unsigned V_VISIBLE = 600,
    parameter int unsigned V_FP      = 1,
    parameter int unsigned V_SYNC    = 4,
    parameter int unsigned V_BP      = 23,
    parameter int unsigned LEAD      = 2,
    parameter bit          SYNC_POL  = 1'b1
) (
    input  logic        clk40,
    input  logic        rst_n,
    output logic [10:0] hPos,
    output logic [9:0]  vPos,
    output logic        videoActive,
    output logic        hsync,
    output logic        vsync,
    output logic [9:0]  nextVPos,
    output logic        nextFrameActive,
    output logic        lineStarting,
    output logic        lineEnding,
    output logic        frameStart,
    output logic [7:0]  frameCount
);

    localparam int unsigned HW       = 11;
    localparam int unsigned VW       = 10;
    localparam int unsigned H_TOTAL  = H_VISIBLE + H_FP + H_SYNC + H_BP;
    localparam int unsigned V_TOTAL  = V_VISIBLE + V_FP + V_SYNC + V_BP;
    localparam int unsigned HS_START = H_VISIBLE + H_FP;
    localparam int unsigned HS_END   = HS_START + H_SYNC;
    localparam int unsigned VS_START = V_VISIBLE + V_FP;
    localparam int unsigned VS_END   = VS_START + V_SYNC;

    // Internal position; parked at the last raster position during reset so the
    // first edge after release lands on (0,0).
    logic [HW-1:0] r_h;
    logic [VW-1:0] r_v;
    // Set after the first edge out of reset; the wrap out of reset is not a frame.
    logic          r_run;

    logic          w_h_wrap;
    logic          w_v_wrap;
    logic [HW-1:0] w_h_nxt;
    logic [VW-1:0] w_v_nxt;
    logic [VW-1:0] w_nv_nxt;
    logic          w_nfa_nxt;

    // Next-state position and next-line look-ahead; outputs decode from these
    // so every registered output matches the position presented with it.
    always_comb begin
        w_h_wrap  = (r_h == HW'(H_TOTAL - 1));
        w_v_wrap  = (r_v == VW'(V_TOTAL - 1));
        w_h_nxt   = w_h_wrap ? '0 : r_h + HW'(1);
        w_v_nxt   = r_v;
        if (w_h_wrap) begin
            w_v_nxt = w_v_wrap ? '0 : r_v + VW'(1);
        end
        w_nv_nxt  = (w_v_nxt == VW'(V_TOTAL - 1)) ? '0 : w_v_nxt + VW'(1);
        w_nfa_nxt = (w_nv_nxt < VW'(V_VISIBLE));
    end

    // Counters and registered decode.
    always_ff @(posedge clk40 or negedge rst_n) begin
        if (!rst_n) begin
            r_h             <= HW'(H_TOTAL - 1);
            r_v             <= VW'(V_TOTAL - 1);
            r_run           <= 1'b0;
            hPos            <= '0;
            vPos            <= '0;
            videoActive     <= 1'b0;
            hsync           <= 1'b0;
            vsync           <= 1'b0;
            nextVPos        <= '0;
            nextFrameActive <= 1'b0;
            lineStarting    <= 1'b0;
            lineEnding      <= 1'b0;
            frameStart      <= 1'b0;
            frameCount      <= '0;
        end else begin
            r_h             <= w_h_nxt;
            r_v             <= w_v_nxt;
            r_run           <= 1'b1;
            hPos            <= w_h_nxt;
            vPos            <= w_v_nxt;
            videoActive     <= (w_h_nxt < HW'(H_VISIBLE)) && (w_v_nxt < VW'(V_VISIBLE));
            hsync           <= ((w_h_nxt >= HW'(HS_START)) && (w_h_nxt < HW'(HS_END)))
                               ? SYNC_POL : ~SYNC_POL;
            vsync           <= ((w_v_nxt >= VW'(VS_START)) && (w_v_nxt < VW'(VS_END)))
                               ? SYNC_POL : ~SYNC_POL;
            nextVPos        <= w_nv_nxt;
            nextFrameActive <= w_nfa_nxt;
            lineStarting    <= (w_h_nxt == HW'(H_TOTAL - LEAD)) && w_nfa_nxt;
            lineEnding      <= (w_h_nxt == HW'(H_VISIBLE - 1)) && (w_v_nxt < VW'(V_VISIBLE));
            frameStart      <= (w_h_nxt == '0) && (w_v_nxt == '0);
            if (w_h_wrap && w_v_wrap && r_run) begin
                frameCount <= frameCount + 8'd1;
            end
        end
    end

endmodule
